// File: rtl/master_out_port.sv
// Transmit half of the serial master-to-slave request channel.
// Latches one request, handshakes, then shifts address/data LSB-first.
module master_out_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  slave_ready,
    output logic                  master_valid,
    output logic                  tx_address,
    output logic                  tx_data,
    output logic                  busy,
    output logic                  tx_done,
    output logic                  tx_timeout
);
    localparam int CW = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(ADDR_WIDTH - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [WW-1:0] WAIT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SEND,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           bit_q, bit_d;
    logic [WW-1:0]           wait_q, wait_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    mv_q, mv_d;
    logic                    txa_q, txa_d;
    logic                    txd_q, txd_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    to_q, to_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            bit_q   <= '0;
            wait_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            mv_q    <= 1'b0;
            txa_q   <= 1'b0;
            txd_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mv_q    <= mv_d;
            txa_q   <= txa_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            to_q    <= to_d;
        end
    end

    // Shadow regs shift right so bit 0 is always the next bit to send;
    // the zero fill blanks data once its width is exhausted.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        data_d  = data_q;
        mv_d    = mv_q;
        txa_d   = 1'b0;
        txd_d   = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        to_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = address;
                    data_d  = write_en ? data : '0;
                    busy_d  = 1'b1;
                    mv_d    = 1'b1;
                    wait_d  = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (slave_ready) begin
                    mv_d    = 1'b0;
                    bit_d   = '0;
                    txa_d   = addr_q[0];
                    txd_d   = data_q[0];
                    addr_d  = addr_q >> 1;
                    data_d  = data_q >> 1;
                    state_d = SEND;
                end else if (TIMEOUT != 0 && wait_q == WAIT_LAST) begin
                    mv_d    = 1'b0;
                    busy_d  = 1'b0;
                    to_d    = 1'b1;
                    state_d = IDLE;
                end else if (wait_q != WAIT_MAX) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            SEND: begin
                if (bit_q != BIT_LAST) begin
                    bit_d  = bit_q + 1'b1;
                    txa_d  = addr_q[0];
                    txd_d  = data_q[0];
                    addr_d = addr_q >> 1;
                    data_d = data_q >> 1;
                end else begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign master_valid = mv_q;
    assign tx_address   = txa_q;
    assign tx_data      = txd_q;
    assign busy         = busy_q;
    assign tx_done      = done_q;
    assign tx_timeout   = to_q;
endmodule
